// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard frame receiver.
//   state_t           : frame receive FSM states
//   PS2_BREAK/PS2_EXT : scancode prefix bytes
//   TIMEOUT_CYCLES_DEFAULT : default inter-edge timeout in sys_clk cycles
package ps2_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic [7:0]  PS2_BREAK              = 8'hF0;
  localparam logic [7:0]  PS2_EXT                = 8'hE0;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 10000;
  localparam int unsigned DATA_BITS              = 8;
  localparam int unsigned BIT_CNT_W              = 3;

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 clock and data lines into sys_clk and flags
// falling edges of the synchronised PS/2 clock.
//   clk, rst     : system clock, synchronous active-high reset
//   ps2_clk/data : raw asynchronous PS/2 lines
//   clk_fall_c   : combinational, high for one cycle per ps2_clk falling edge
//   data_sync    : synchronised ps2_data, aligned with clk_fall_c
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_fall_c,
  output logic data_sync
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic                   clk_prev;

  // Both lines idle high, so the chains reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  assign clk_fall_c = clk_prev & ~clk_sr[SYNC_STAGES-1];
  assign data_sync  = data_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver and scancode decoder. Receives 11-bit frames
// (start, 8 data LSB first, odd parity, stop), folds F0/E0 prefixes into
// release/extended flags and reports each completed key event.
//   sys_clk, rst  : system clock, synchronous active-high reset
//   ps2_clk/data  : raw asynchronous PS/2 lines
//   key_code      : last completed scancode
//   key_release   : key_code was preceded by F0
//   key_extended  : key_code was preceded by E0
//   key_valid     : one-cycle pulse when key outputs update
//   frame_err     : one-cycle pulse on start/parity/stop/timeout error
module ps2_frame_rx
  import ps2_frame_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic fall_c;
  logic data_sync;

  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (sys_clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .clk_fall_c (fall_c),
    .data_sync  (data_sync)
  );

  state_t               state,     state_n;
  logic [BIT_CNT_W-1:0] bit_cnt,   bit_cnt_n;
  logic [7:0]           shift,     shift_n;
  logic                 parity_ok, parity_ok_n;
  logic                 pend_rel,  pend_rel_n;
  logic                 pend_ext,  pend_ext_n;
  logic [TMO_W-1:0]     tmo_cnt,   tmo_cnt_n;
  logic [7:0]           code_n;
  logic                 rel_n, ext_n, valid_n, err_n;

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift        <= 8'h00;
      parity_ok    <= 1'b0;
      pend_rel     <= 1'b0;
      pend_ext     <= 1'b0;
      tmo_cnt      <= '0;
      key_code     <= 8'h00;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      key_valid    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      shift        <= shift_n;
      parity_ok    <= parity_ok_n;
      pend_rel     <= pend_rel_n;
      pend_ext     <= pend_ext_n;
      tmo_cnt      <= tmo_cnt_n;
      key_code     <= code_n;
      key_release  <= rel_n;
      key_extended <= ext_n;
      key_valid    <= valid_n;
      frame_err    <= err_n;
    end
  end

  // Next-state, frame decode and scancode prefix handling.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    parity_ok_n = parity_ok;
    pend_rel_n  = pend_rel;
    pend_ext_n  = pend_ext;
    tmo_cnt_n   = tmo_cnt;
    code_n      = key_code;
    rel_n       = key_release;
    ext_n       = key_extended;
    valid_n     = 1'b0;
    err_n       = 1'b0;

    // Saturating inter-edge timer, only meaningful inside a frame.
    if (state != ST_IDLE && tmo_cnt != '1) begin
      tmo_cnt_n = tmo_cnt + TMO_W'(1);
    end

    if (fall_c) begin
      tmo_cnt_n = '0;
      case (state)
        ST_IDLE: begin
          if (!data_sync) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end else begin
            err_n      = 1'b1;
            pend_rel_n = 1'b0;
            pend_ext_n = 1'b0;
          end
        end
        ST_DATA: begin
          shift_n   = {data_sync, shift[7:1]};
          bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_n = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_ok_n = ^{data_sync, shift};
          state_n     = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (data_sync && parity_ok) begin
            if (shift == PS2_BREAK) begin
              pend_rel_n = 1'b1;
            end else if (shift == PS2_EXT) begin
              pend_ext_n = 1'b1;
            end else begin
              code_n     = shift;
              rel_n      = pend_rel;
              ext_n      = pend_ext;
              valid_n    = 1'b1;
              pend_rel_n = 1'b0;
              pend_ext_n = 1'b0;
            end
          end else begin
            err_n      = 1'b1;
            pend_rel_n = 1'b0;
            pend_ext_n = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && tmo_cnt >= TMO_W'(TIMEOUT_CYCLES)) begin
      state_n    = ST_IDLE;
      tmo_cnt_n  = '0;
      err_n      = 1'b1;
      pend_rel_n = 1'b0;
      pend_ext_n = 1'b0;
    end
  end

endmodule
